// File: rtl/ctrl_seg_pipe.sv
// Chain of DEPTH control-bundle registers with per-stage hold (bubble) and clear (flush).
// Also keeps saturating counts of stalled cycles and of cycles that flushed a live instruction.
module ctrl_seg_pipe #(
    parameter int unsigned      WIDTH     = 9,
    parameter int unsigned      DEPTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid_in,
    input  logic [WIDTH-1:0]       ctrl_in,
    input  logic [DEPTH-1:0]       bubble,
    input  logic [DEPTH-1:0]       flush,
    output logic [DEPTH*WIDTH-1:0] ctrl_out,
    output logic [DEPTH-1:0]       valid_out,
    output logic [15:0]            stall_cnt,
    output logic [15:0]            kill_cnt
);

    logic [WIDTH-1:0] r_ctrl [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [15:0]      r_stall_cnt;
    logic [15:0]      r_kill_cnt;

    logic [WIDTH-1:0] w_src_ctrl  [DEPTH];
    logic [WIDTH-1:0] w_next_ctrl [DEPTH];
    logic [DEPTH-1:0] w_src_valid;
    logic [DEPTH-1:0] w_up_held;
    logic [DEPTH-1:0] w_take;
    logic [DEPTH-1:0] w_next_valid;
    logic             w_any_stall;
    logic             w_any_kill;
    logic [15:0]      w_stall_nxt;
    logic [15:0]      w_kill_nxt;

    genvar i;
    generate
        for (i = 0; i < DEPTH; i++) begin : g_stage
            if (i == 0) begin : g_head
                assign w_src_valid[i] = valid_in;
                assign w_src_ctrl[i]  = ctrl_in;
                assign w_up_held[i]   = 1'b0;
            end else begin : g_body
                assign w_src_valid[i] = r_valid[i-1];
                assign w_src_ctrl[i]  = r_ctrl[i-1];
                // A held upstream stage would otherwise hand us the same instruction twice.
                assign w_up_held[i]   = bubble[i-1];
            end

            assign w_take[i]       = w_src_valid[i] & ~flush[i] & ~w_up_held[i];
            assign w_next_valid[i] = bubble[i] ? r_valid[i] : w_take[i];
            assign w_next_ctrl[i]  = bubble[i] ? r_ctrl[i]
                                   : (w_take[i] ? w_src_ctrl[i] : RESET_VAL);

            assign ctrl_out[i*WIDTH +: WIDTH] = r_ctrl[i];
        end
    endgenerate

    assign w_any_stall = |bubble;
    assign w_any_kill  = |(flush & ~bubble & r_valid);

    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        w_stall_nxt = r_stall_cnt;
        w_kill_nxt  = r_kill_cnt;
        if (w_any_stall && (r_stall_cnt != 16'hFFFF)) begin
            w_stall_nxt = r_stall_cnt + 16'd1;
        end
        if (w_any_kill && (r_kill_cnt != 16'hFFFF)) begin
            w_kill_nxt = r_kill_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every stage samples its neighbour's pre-edge value.
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_ctrl[k] <= RESET_VAL;
            end
            r_valid     <= '0;
            r_stall_cnt <= '0;
            r_kill_cnt  <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                r_ctrl[k] <= w_next_ctrl[k];
            end
            r_valid     <= w_next_valid;
            r_stall_cnt <= w_stall_nxt;
            r_kill_cnt  <= w_kill_nxt;
        end
    end

    assign valid_out = r_valid;
    assign stall_cnt = r_stall_cnt;
    assign kill_cnt  = r_kill_cnt;

endmodule
